branch_resolve_unit: RTL and testbench

Resolution end of the branch-prediction loop. Captures each beq/bne fetched with the 2-bit predictor's taken/not-taken bit, tracks it to ID, compares the prediction against the ID-stage outcome, and drives the mispredict pulse back to the predictor. The same pulse flushes IF. The unit also supplies the recovery PC and keeps saturating branch and mispredict counters. Sits between the IF/ID pipeline register and the PC-select mux.

---
 rtl/branch_resolve_unit.sv | 162 ++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
`default_nettype none
//==============================================================================
// Module   : branch_resolve_unit
// Brief    : Tracks a predicted beq/bne from IF into ID, checks the prediction
//            against the ID-stage outcome, and raises the mispredict, flush and
//            redirect signals. Supplies the recovery PC and keeps saturating
//            branch and mispredict counters.
// Revision : 1.0  initial release
//==============================================================================
module branch_resolve_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             if_valid,
    input  logic [5:0]       if_opcode,
    input  logic [31:0]      if_pc,
    input  logic [15:0]      if_imm,
    input  logic             brpre,
    input  logic [1:0]       ctrl_br,
    input  logic             id_equal,
    output logic             pre_wrong,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic             proto_err
);

    localparam logic [5:0] c_OP_BEQ  = 6'h04;
    localparam logic [5:0] c_OP_BNE  = 6'h05;
    localparam logic [1:0] c_BR_NONE = 2'b00;
    localparam logic [1:0] c_BR_BEQ  = 2'b01;
    localparam logic [1:0] c_BR_BNE  = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_brpre;
    logic [31:0]       r_alt_pc;
    logic [CNT_W-1:0]  r_br_cnt;
    logic [CNT_W-1:0]  r_miss_cnt;
    logic              r_proto_err;

    logic              w_is_branch;
    logic              w_capture;
    logic              w_ctrl_valid;
    logic              w_actual_taken;
    logic              w_resolve;
    logic              w_wrong;
    logic              w_proto;
    logic              w_load;
    logic [31:0]       w_pc_seq;
    logic [31:0]       w_offset;
    logic [31:0]       w_alt_pc;

    // Decode the IF instruction and the ID outcome; derive the resolve events.
    always_comb begin
        w_is_branch    = if_valid && ((if_opcode == c_OP_BEQ) || (if_opcode == c_OP_BNE));
        w_capture      = !stall && w_is_branch && (r_state != RECOVER);
        w_ctrl_valid   = (ctrl_br == c_BR_BEQ) || (ctrl_br == c_BR_BNE);
        w_actual_taken = ((ctrl_br == c_BR_BEQ) && id_equal) ||
                         ((ctrl_br == c_BR_BNE) && !id_equal);
        w_resolve      = (r_state == PEND) && !stall && w_ctrl_valid;
        w_wrong        = w_resolve && (r_brpre ^ w_actual_taken);
        w_proto        = (r_state == PEND) && !stall && !w_ctrl_valid;
        // The alternate PC is the path the predictor did not choose.
        w_pc_seq       = if_pc + 32'd4;
        w_offset       = {{14{if_imm[15]}}, if_imm, 2'b00};
        w_alt_pc       = brpre ? w_pc_seq : (w_pc_seq + w_offset);
    end

    // Next-state and tracking-load decision.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_capture) begin
                    w_state_nxt = PEND;
                    w_load      = 1'b1;
                end
            end
            PEND: begin
                if (stall) begin
                    w_state_nxt = PEND;
                end else if (w_wrong) begin
                    // IF holds the wrong path; it is squashed, never captured.
                    w_state_nxt = RECOVER;
                end else if (w_capture) begin
                    // Correct resolve or protocol error: a new branch may follow.
                    w_state_nxt = PEND;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RECOVER: begin
                w_state_nxt = stall ? RECOVER : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Tracked prediction and alternate PC of the branch in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_brpre  <= 1'b0;
            r_alt_pc <= 32'd0;
        end else if (w_load) begin
            r_brpre  <= brpre;
            r_alt_pc <= w_alt_pc;
        end
    end

    // Saturating statistics counters and the sticky protocol-error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_cnt    <= '0;
            r_miss_cnt  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_resolve && !(&r_br_cnt)) begin
                r_br_cnt <= r_br_cnt + 1'b1;
            end
            if (w_wrong && !(&r_miss_cnt)) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
            if (w_proto) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign pre_wrong      = w_wrong;
    assign flush          = w_wrong;
    assign redirect_valid = w_wrong;
    assign redirect_pc    = r_alt_pc;
    assign br_cnt         = r_br_cnt;
    assign miss_cnt       = r_miss_cnt;
    assign proto_err      = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
//==============================================================================
// Module   : tb_branch_resolve_unit
// Brief    : Directed self-checking bench for branch_resolve_unit with a queue
//            of expected per-cycle results.
// Revision : 1.0  initial release
//==============================================================================
module tb_branch_resolve_unit;

    localparam int CNT_W = 4;
    localparam logic [5:0] BEQ = 6'h04;
    localparam logic [5:0] BNE = 6'h05;

    logic             clk;
    logic             rst_n;
    logic             stall;
    logic             if_valid;
    logic [5:0]       if_opcode;
    logic [31:0]      if_pc;
    logic [15:0]      if_imm;
    logic             brpre;
    logic [1:0]       ctrl_br;
    logic             id_equal;
    logic             pre_wrong;
    logic             flush;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] miss_cnt;
    logic             proto_err;

    branch_resolve_unit #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .if_valid       (if_valid),
        .if_opcode      (if_opcode),
        .if_pc          (if_pc),
        .if_imm         (if_imm),
        .brpre          (brpre),
        .ctrl_br        (ctrl_br),
        .id_equal       (id_equal),
        .pre_wrong      (pre_wrong),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .br_cnt         (br_cnt),
        .miss_cnt       (miss_cnt),
        .proto_err      (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        pw;
        logic        chk_rpc;
        logic [31:0] rpc;
        logic [3:0]  bc;
        logic [3:0]  mc;
        logic        pe;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic v, input logic [5:0] op,
                         input logic [31:0] pc, input logic [15:0] imm, input logic bp,
                         input logic [1:0] cb, input logic eq);
        stall = st; if_valid = v; if_opcode = op; if_pc = pc;
        if_imm = imm; brpre = bp; ctrl_br = cb; id_equal = eq;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 6'h00, 32'h0, 16'h0, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic expect_cyc(input string tag, input logic pw, input logic crpc,
                              input logic [31:0] rpc, input logic [3:0] bc,
                              input logic [3:0] mc, input logic pe);
        exp_t e;
        e.tag = tag; e.pw = pw; e.chk_rpc = crpc; e.rpc = rpc;
        e.bc = bc; e.mc = mc; e.pe = pe;
        q.push_back(e);
    endtask

    // Sample on the falling edge, compare against the oldest expectation,
    // then advance to just after the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            chk({e.tag, ".pre_wrong"}, 32'(pre_wrong), 32'(e.pw));
            chk({e.tag, ".flush"}, 32'(flush), 32'(e.pw));
            chk({e.tag, ".redirect_valid"}, 32'(redirect_valid), 32'(e.pw));
            if (e.chk_rpc) chk({e.tag, ".redirect_pc"}, redirect_pc, e.rpc);
            chk({e.tag, ".br_cnt"}, 32'(br_cnt), 32'(e.bc));
            chk({e.tag, ".miss_cnt"}, 32'(miss_cnt), 32'(e.mc));
            chk({e.tag, ".proto_err"}, 32'(proto_err), 32'(e.pe));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] bc;
        logic [3:0] mc;
        rst_n = 1'b0;
        idle_in();
        #3;
        chk("rst.pre_wrong", 32'(pre_wrong), 32'd0);
        chk("rst.br_cnt", 32'(br_cnt), 32'd0);
        chk("rst.miss_cnt", 32'(miss_cnt), 32'd0);
        chk("rst.proto_err", 32'(proto_err), 32'd0);
        chk("rst.redirect_pc", redirect_pc, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Correct not-taken branch
        drive(0, 1, BEQ, 32'h100, 16'h0004, 0, 2'b00, 0);
        expect_cyc("nt_ok_cap", 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 6'h0, 32'h0, 16'h0, 0, 2'b01, 0);
        expect_cyc("nt_ok_res", 0, 1, 32'h114, 0, 0, 0); tick();
        idle_in();
        expect_cyc("nt_ok_after", 0, 0, 0, 1, 0, 0); tick();

        // Not-taken mispredict; RECOVER ignores an IF beq
        drive(0, 1, BEQ, 32'h100, 16'h0004, 0, 2'b00, 0);
        expect_cyc("nt_miss_cap", 0, 0, 0, 1, 0, 0); tick();
        drive(0, 1, BEQ, 32'h180, 16'h0004, 1, 2'b01, 1);
        expect_cyc("nt_miss_res", 1, 1, 32'h114, 1, 0, 0); tick();
        drive(0, 1, BEQ, 32'h400, 16'h0008, 0, 2'b01, 1);
        expect_cyc("nt_miss_recover", 0, 1, 32'h114, 2, 1, 0); tick();
        drive(0, 0, 6'h0, 32'h0, 16'h0, 0, 2'b01, 1);
        expect_cyc("nt_miss_idle", 0, 1, 32'h114, 2, 1, 0); tick();

        // Taken mispredict, negative offset (predicted target 0x1FC)
        drive(0, 1, BNE, 32'h200, 16'hFFFE, 1, 2'b00, 0);
        expect_cyc("tk_miss_cap", 0, 0, 0, 2, 1, 0); tick();
        drive(0, 0, 6'h0, 32'h0, 16'h0, 0, 2'b10, 1);
        expect_cyc("tk_miss_res", 1, 1, 32'h204, 2, 1, 0); tick();
        idle_in();
        expect_cyc("tk_miss_recover", 0, 0, 0, 3, 2, 0); tick();

        // Stall three cycles in the resolve cycle, then release with a mismatch
        drive(0, 1, BEQ, 32'h500, 16'h0010, 0, 2'b00, 0);
        expect_cyc("stall_cap", 0, 0, 0, 3, 2, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, BNE, 32'h600, 16'h0001, 1, 2'b01, 1);
            expect_cyc($sformatf("stall_hold%0d", i), 0, 1, 32'h544, 3, 2, 0); tick();
        end
        drive(0, 0, 6'h0, 32'h0, 16'h0, 0, 2'b01, 1);
        expect_cyc("stall_release", 1, 1, 32'h544, 3, 2, 0); tick();
        idle_in();
        expect_cyc("stall_after", 0, 0, 0, 4, 3, 0); tick();

        // Back-to-back correct branches at 0x300 / 0x304
        drive(0, 1, BEQ, 32'h300, 16'h0008, 0, 2'b00, 0);
        expect_cyc("b2b_cap1", 0, 0, 0, 4, 3, 0); tick();
        drive(0, 1, BEQ, 32'h304, 16'h0008, 1, 2'b01, 0);
        expect_cyc("b2b_res1", 0, 1, 32'h324, 4, 3, 0); tick();
        drive(0, 0, 6'h0, 32'h0, 16'h0, 0, 2'b01, 1);
        expect_cyc("b2b_res2", 0, 1, 32'h308, 5, 3, 0); tick();
        idle_in();
        expect_cyc("b2b_after", 0, 0, 0, 6, 3, 0); tick();

        // ctrl_br=00 while tracking: sticky proto_err, tracking dropped
        drive(0, 1, BEQ, 32'h700, 16'h0000, 0, 2'b00, 0);
        expect_cyc("proto_cap", 0, 0, 0, 6, 3, 0); tick();
        idle_in();
        expect_cyc("proto_bad", 0, 0, 0, 6, 3, 0); tick();
        drive(0, 0, 6'h0, 32'h0, 16'h0, 0, 2'b01, 1);
        expect_cyc("proto_dropped", 0, 0, 0, 6, 3, 1); tick();

        // Branch counter saturation over 20 correct resolves
        for (int i = 0; i < 20; i++) begin
            bc = (6 + i > 15) ? 4'hF : 4'(6 + i);
            drive(0, 1, BEQ, 32'h800 + 32'(i * 16), 16'h0002, 0, 2'b00, 0);
            expect_cyc($sformatf("sat_br_cap%0d", i), 0, 0, 0, bc, 3, 1); tick();
            drive(0, 0, 6'h0, 32'h0, 16'h0, 0, 2'b01, 0);
            expect_cyc($sformatf("sat_br_res%0d", i), 0, 0, 0, bc, 3, 1); tick();
        end
        idle_in();
        expect_cyc("sat_br_final", 0, 0, 0, 4'hF, 3, 1); tick();

        // Mispredict counter saturation over 14 mispredicts
        for (int j = 0; j < 14; j++) begin
            mc = (3 + j > 15) ? 4'hF : 4'(3 + j);
            drive(0, 1, BNE, 32'h900, 16'h0003, 1, 2'b00, 0);
            expect_cyc($sformatf("sat_mc_cap%0d", j), 0, 0, 0, 4'hF, mc, 1); tick();
            drive(0, 0, 6'h0, 32'h0, 16'h0, 0, 2'b10, 1);
            expect_cyc($sformatf("sat_mc_res%0d", j), 1, 1, 32'h904, 4'hF, mc, 1); tick();
            idle_in();
            tick_recover: begin
                mc = (4 + j > 15) ? 4'hF : 4'(4 + j);
                expect_cyc($sformatf("sat_mc_rec%0d", j), 0, 0, 0, 4'hF, mc, 1); tick();
            end
        end

        // Asynchronous reset mid-cycle while a mispredict pulse is active
        drive(0, 1, BEQ, 32'hA00, 16'h0004, 0, 2'b00, 0);
        expect_cyc("arst_cap", 0, 0, 0, 4'hF, 4'hF, 1); tick();
        drive(0, 0, 6'h0, 32'h0, 16'h0, 0, 2'b01, 1);
        #2;
        chk("arst_pre.pre_wrong", 32'(pre_wrong), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst.pre_wrong", 32'(pre_wrong), 32'd0);
        chk("arst.flush", 32'(flush), 32'd0);
        chk("arst.redirect_valid", 32'(redirect_valid), 32'd0);
        chk("arst.redirect_pc", redirect_pc, 32'd0);
        chk("arst.br_cnt", 32'(br_cnt), 32'd0);
        chk("arst.miss_cnt", 32'(miss_cnt), 32'd0);
        chk("arst.proto_err", 32'(proto_err), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(0, 0, 6'h0, 32'h0, 16'h0, 0, 2'b01, 1);
        expect_cyc("arst_after", 0, 0, 0, 0, 0, 0); tick();

        if (q.size() != 0) chk("scoreboard_leftover", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit so the bench always ends on its own.
    initial begin
        #200000;
        n_errors++;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
